// File: rtl/wb_queue_pkg.sv
// Shared CPU constants and the pending-writeback entry type used by the writeback queue.
package wb_queue_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned DATA_W    = 32;
    localparam logic [REG_IDX_W-1:0] PC_IDX = REG_IDX_W'(15);

    typedef struct packed {
        logic [REG_IDX_W-1:0] addr;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

    function automatic logic is_pc(input logic [REG_IDX_W-1:0] idx);
        return idx == PC_IDX;
    endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Producer, drain and forwarding-lookup signals of the writeback queue.
interface wb_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    import wb_queue_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [REG_IDX_W-1:0] in_addr;
    logic [DATA_W-1:0]    in_data;
    logic                 drain_en;
    logic                 wrEn;
    logic [REG_IDX_W-1:0] wrAddr;
    logic [DATA_W-1:0]    wrData;
    logic [REG_IDX_W-1:0] lkAddr1;
    logic [REG_IDX_W-1:0] lkAddr2;
    logic                 lkHit1;
    logic                 lkHit2;
    logic [DATA_W-1:0]    lkData1;
    logic [DATA_W-1:0]    lkData2;
    logic [CNT_W-1:0]     count;

    modport master (
        output in_valid, in_addr, in_data, drain_en, lkAddr1, lkAddr2,
        input  in_ready, wrEn, wrAddr, wrData, lkHit1, lkHit2, lkData1, lkData2, count
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_en, lkAddr1, lkAddr2,
        output in_ready, wrEn, wrAddr, wrData, lkHit1, lkHit2, lkData1, lkData2, count
    );

endinterface

// File: rtl/wb_fwd_match.sv
// Youngest-match forwarding search over the occupied entries of the writeback queue.
module wb_fwd_match
    import wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t                  i_entries [DEPTH],
    input  logic [DEPTH-1:0]           i_valid,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_ptr,
    input  logic [REG_IDX_W-1:0]       i_lk_addr,
    output logic                       o_hit,
    output logic [DATA_W-1:0]          o_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        // Walk from the head (oldest) towards the tail so the youngest match overrides.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = i_rd_ptr + PTR_W'(i);
            if (i_valid[w_idx] && (i_entries[w_idx].addr == i_lk_addr) && !is_pc(i_lk_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Circular writeback queue: head drives the register-file write port, pending entries are
// visible to two forwarding lookups. Writes to the PC index are accepted and dropped.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    wb_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t          r_entries [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    wb_entry_t          w_in_entry;
    wb_entry_t          w_head;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.in_valid && !w_full && !is_pc(bus.in_addr);
    assign w_pop      = !w_empty && bus.drain_en;
    assign w_in_entry = '{addr: bus.in_addr, data: bus.in_data};
    assign w_head     = r_entries[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Payload storage is qualified by r_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_wr_ptr] <= w_in_entry;
        end
    end

    assign bus.in_ready = !w_full;
    assign bus.wrEn     = !w_empty;
    assign bus.wrAddr   = w_empty ? '0 : w_head.addr;
    assign bus.wrData   = w_empty ? '0 : w_head.data;
    assign bus.count    = r_count;

    wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd1 (
        .i_entries (r_entries),
        .i_valid   (r_valid),
        .i_rd_ptr  (r_rd_ptr),
        .i_lk_addr (bus.lkAddr1),
        .o_hit     (bus.lkHit1),
        .o_data    (bus.lkData1)
    );

    wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd2 (
        .i_entries (r_entries),
        .i_valid   (r_valid),
        .i_rd_ptr  (r_rd_ptr),
        .i_lk_addr (bus.lkAddr2),
        .o_hit     (bus.lkHit2),
        .o_data    (bus.lkData2)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: the driver queues accepted writebacks, the monitor checks
// every output each cycle against that queue and retires the head on each drain.
module tb_wb_queue;
    import wb_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    bit   mon_en;
    int   vectors;
    int   miscompares;

    wb_entry_t exp_q [$];

    wb_queue_if #(.DEPTH(DEPTH)) bus ();

    wb_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Youngest pending write to a register, searching back from the tail.
    function automatic void model_lookup(input logic [3:0] a, output logic hit,
                                         output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 4'd15) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].addr == a) begin
                    hit = 1'b1;
                    d   = exp_q[i].data;
                    break;
                end
            end
        end
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ".count"},   32'(bus.count),  32'd0);
        check({tag, ".inready"}, 32'(bus.in_ready), 32'd1);
        check({tag, ".wrEn"},    32'(bus.wrEn),   32'd0);
        check({tag, ".wrAddr"},  32'(bus.wrAddr), 32'd0);
        check({tag, ".wrData"},  bus.wrData,      32'd0);
        check({tag, ".lkHit1"},  32'(bus.lkHit1), 32'd0);
        check({tag, ".lkHit2"},  32'(bus.lkHit2), 32'd0);
        check({tag, ".lkData1"}, bus.lkData1,     32'd0);
        check({tag, ".lkData2"}, bus.lkData2,     32'd0);
    endtask

    // Monitor: samples shortly before each rising edge, after the driver has settled inputs.
    initial begin
        int          n;
        logic        hit;
        logic [31:0] dat;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                n = exp_q.size();
                check("count",   32'(bus.count),    32'(n));
                check("inready", 32'(bus.in_ready), 32'(n < DEPTH));
                check("wrEn",    32'(bus.wrEn),     32'(n != 0));
                check("wrAddr",  32'(bus.wrAddr),   (n != 0) ? 32'(exp_q[0].addr) : 32'd0);
                check("wrData",  bus.wrData,        (n != 0) ? exp_q[0].data : 32'd0);
                model_lookup(bus.lkAddr1, hit, dat);
                check("lkHit1",  32'(bus.lkHit1),   32'(hit));
                check("lkData1", bus.lkData1,       dat);
                model_lookup(bus.lkAddr2, hit, dat);
                check("lkHit2",  32'(bus.lkHit2),   32'(hit));
                check("lkData2", bus.lkData2,       dat);
                if (n != 0 && bus.drain_en) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cycle(input logic v, input logic [3:0] a, input logic [31:0] d,
                         input logic dr, input logic [3:0] l1, input logic [3:0] l2);
        wb_entry_t e;
        logic      acc;
        @(negedge clk);
        #1;
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.drain_en = dr;
        bus.lkAddr1  = l1;
        bus.lkAddr2  = l2;
        acc = v && (exp_q.size() < DEPTH) && (a != 4'd15);
        #3;
        if (acc) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        mon_en       = 1'b0;
        bus.in_valid = 1'b0;
        bus.drain_en = 1'b0;
        bus.lkAddr1  = (exp_q.size() != 0) ? exp_q[0].addr : 4'd3;
        bus.lkAddr2  = (exp_q.size() != 0) ? exp_q[exp_q.size()-1].addr : 4'd3;
        #2;
        rst = 1'b0;
        #1;
        check_reset("midrst");
        exp_q.delete();
        @(negedge clk);
        #1;
        check_reset("rsthold");
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        mon_en       = 1'b0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.drain_en = 1'b0;
        bus.lkAddr1  = 4'd3;
        bus.lkAddr2  = 4'd5;
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset");
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single push, visible next cycle on the write port and lookup, then drained.
        cycle(1, 4'd3, 32'hDEADBEEF, 0, 4'd3, 4'd3);
        cycle(0, 4'd0, 32'h0, 0, 4'd3, 4'd7);
        cycle(0, 4'd0, 32'h0, 1, 4'd3, 4'd3);
        cycle(0, 4'd0, 32'h0, 0, 4'd3, 4'd3);

        // Repeated index: youngest forwarded, both drained in order.
        cycle(1, 4'd5, 32'h1, 0, 4'd5, 4'd5);
        cycle(1, 4'd5, 32'h2, 0, 4'd5, 4'd5);
        cycle(0, 4'd0, 32'h0, 0, 4'd5, 4'd5);
        cycle(0, 4'd0, 32'h0, 1, 4'd5, 4'd5);
        cycle(0, 4'd0, 32'h0, 1, 4'd5, 4'd5);
        cycle(0, 4'd0, 32'h0, 0, 4'd5, 4'd5);

        // Fill, offer while full, then stream across pointer wrap.
        for (int i = 0; i < DEPTH; i++) cycle(1, 4'(i + 1), 32'h100 + 32'(i), 0, 4'd2, 4'd4);
        cycle(1, 4'd9, 32'hBAD0, 0, 4'd9, 4'd1);
        cycle(1, 4'd9, 32'hBAD1, 1, 4'd9, 4'd1);
        for (int i = 0; i < 10; i++) cycle(1, 4'(i % 3 + 6), 32'h200 + 32'(i), 1, 4'd6, 4'd8);
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 4'd0, 32'h0, 1, 4'd7, 4'd8);

        // PC index handshakes but never enqueues or hits.
        cycle(1, 4'd15, 32'hAAAA, 0, 4'd15, 4'd15);
        cycle(0, 4'd0, 32'h0, 0, 4'd15, 4'd15);

        // Simultaneous push and pop at count 2.
        cycle(1, 4'd1, 32'h11, 0, 4'd1, 4'd2);
        cycle(1, 4'd2, 32'h22, 0, 4'd1, 4'd2);
        cycle(1, 4'd1, 32'h33, 1, 4'd1, 4'd2);
        cycle(0, 4'd0, 32'h0, 0, 4'd1, 4'd2);

        // Bring count to 3 and reset between edges.
        cycle(1, 4'd4, 32'h44, 0, 4'd4, 4'd1);
        cycle(0, 4'd0, 32'h0, 0, 4'd4, 4'd1);
        mid_reset();
        cycle(0, 4'd0, 32'h0, 1, 4'd4, 4'd1);

        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end
        cycle(0, 4'd0, 32'h0, 0, 4'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
